// File: rtl/adc_pkg.sv
// Shared ADC/DAC definitions: default widths, full-scale value and the
// code mapping used on both the DAC output path and the ADC capture path.
package adc_pkg;

    localparam int ADC_DATA_W  = 8;
    localparam int ADC_CLK_DIV = 50;

    localparam logic [ADC_DATA_W-1:0] FULL_SCALE = '1;

    function automatic logic [ADC_DATA_W-1:0] code_map(
        input logic [ADC_DATA_W-1:0] code,
        input logic                  invert
    );
        return invert ? FULL_SCALE - code : code;
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// First-word-fall-through sample buffer with extra-bit pointers.
// Reset discards contents by clearing the pointers.
module sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    // A write into a full buffer is legal when the head leaves this cycle
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_capture.sv
// Parallel ADC capture: sample clock divider, code mapping, sample buffer
// and back-pressure drop accounting.
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int CLK_DIV    = ADC_CLK_DIV,
    parameter bit INVERT     = 1'b1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] ad_data,
    output logic              adc_clk,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_ovf,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] ad_q;
    logic [DATA_W-1:0] conv;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] hold_q;
    logic              strobe;
    logic              pop;
    logic              drop;
    logic              empty;
    logic              full;

    assign strobe = en && (cnt == CNT_LAST);
    assign pop    = !empty && out_ready;
    assign drop   = strobe && full && !pop;

    generate
        if (DATA_W == ADC_DATA_W) begin : g_pkg_map
            assign conv = code_map(ad_q, INVERT);
        end else begin : g_local_map
            assign conv = INVERT ? ~ad_q : ad_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            adc_clk <= 1'b0;
            ad_q    <= '0;
        end else begin
            ad_q    <= ad_data;
            adc_clk <= en && (cnt < CNT_HALF);
            if (!en || cnt == CNT_LAST) cnt <= '0;
            else                        cnt <= cnt + 1'b1;
        end
    end

    sample_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (strobe),
        .wr_data (conv),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .full    (full)
    );

    // Last popped word is shown once the buffer runs dry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_q <= '0;
        else if (pop) hold_q <= head;
    end

    assign out_valid = !empty;
    assign out_data  = empty ? hold_q : head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (clr_ovf)
                drop_cnt <= drop ? CNT_W'(1) : '0;
            else if (drop && drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: one inverting and one pass-through
// instance with a narrow drop counter, driven from shared stimulus.
module tb_adc_capture;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] ad_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;

    logic        adc_clk_a, adc_clk_b;
    logic [7:0]  out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b;
    logic        overflow_a, overflow_b;
    logic [15:0] drop_cnt_a;
    logic [3:0]  drop_cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    bit ramp = 1'b0;

    always #5 clk = ~clk;

    adc_capture #(
        .DATA_W(8), .CLK_DIV(4), .INVERT(1'b1), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .ad_data(ad_data),
        .adc_clk(adc_clk_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .clr_ovf(clr_ovf), .overflow(overflow_a), .drop_cnt(drop_cnt_a)
    );

    adc_capture #(
        .DATA_W(8), .CLK_DIV(4), .INVERT(1'b0), .FIFO_DEPTH(4), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .ad_data(ad_data),
        .adc_clk(adc_clk_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .clr_ovf(clr_ovf), .overflow(overflow_b), .drop_cnt(drop_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (t=%0d): got %0h expected %0h",
                     tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        if (ramp) ad_data = t[7:0];
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    // Cycle 0 begins here: en high, divider at 0
    task automatic start(input bit ramp_in);
        reset_n   = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", out_valid_a, 0);
        check("rst_data", out_data_a, 0);
        check("rst_adc_clk", adc_clk_a, 0);
        check("rst_ovf", overflow_a, 0);
        check("rst_drop", drop_cnt_a, 0);
        ramp    = ramp_in;
        ad_data = ramp_in ? 8'h00 : 8'h10;
        reset_n = 1'b1;
        en      = 1'b1;
        t       = 0;
    endtask

    initial begin
        // 1: constant input, free-flowing output
        start(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("t1_adc_clk", adc_clk_a, (t % 4 == 1 || t % 4 == 2));
            check("t1_valid_a", out_valid_a, (t % 4 == 0));
            check("t1_valid_b", out_valid_b, (t % 4 == 0));
            if (t % 4 == 0) begin
                check("t1_data_a", out_data_a, 8'hEF);
                check("t1_data_b", out_data_b, 8'h10);
            end
        end

        // 2: ramp, each output is ad_data from the cycle before strobe
        start(1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            check("t2_valid", out_valid_b, (t % 4 == 0));
            if (t % 4 == 0) begin
                check("t2_data_b", out_data_b, t - 2);
                check("t2_data_a", out_data_a, 255 - (t - 2));
            end
        end

        // 3: ten strobes with no reader, then drain
        start(1'b1);
        run_to(19);
        check("t3_ovf_pre", overflow_b, 0);
        step();
        check("t3_ovf_set", overflow_b, 1);
        check("t3_drop1", drop_cnt_a, 1);
        run_to(30);
        check("t3_stable_v", out_valid_b, 1);
        check("t3_stable_d", out_data_b, 2);
        run_to(40);
        check("t3_drop_a", drop_cnt_a, 6);
        check("t3_drop_b", drop_cnt_b, 6);
        check("t3_ovf", overflow_a, 1);
        en = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t3_drain_v", out_valid_b, 1);
            check("t3_drain_d", out_data_b, 4 * k + 2);
            step();
        end
        check("t3_empty", out_valid_b, 0);
        check("t3_hold_b", out_data_b, 14);
        check("t3_hold_a", out_data_a, 241);

        // 4a: full buffer, pop coincident with strobe
        start(1'b1);
        run_to(19);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t4_nodrop", drop_cnt_a, 0);
        check("t4_noovf", overflow_a, 0);
        check("t4_head", out_data_b, 6);
        run_to(24);
        check("t4_drop_next", drop_cnt_a, 1);
        en = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_drain_v", out_valid_b, 1);
            check("t4_drain_d", out_data_b, 4 * k + 6);
            step();
        end
        check("t4_empty", out_valid_b, 0);

        // 4b: drop counter saturation and clear
        start(1'b1);
        run_to(80);
        check("t4_sat_b80", drop_cnt_b, 15);
        check("t4_cnt_a80", drop_cnt_a, 16);
        run_to(96);
        check("t4_sat_b", drop_cnt_b, 15);
        check("t4_cnt_a", drop_cnt_a, 20);
        run_to(99);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4_clr_drop_ovf", overflow_a, 1);
        check("t4_clr_drop_a", drop_cnt_a, 1);
        check("t4_clr_drop_b", drop_cnt_b, 1);
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4_clr_ovf", overflow_a, 0);
        check("t4_clr_cnt", drop_cnt_a, 0);

        // 5: enable dropped at cnt=2 for three cycles
        start(1'b1);
        run_to(6);
        check("t5_head_v", out_valid_b, 1);
        check("t5_head_d", out_data_b, 2);
        en = 1'b0;
        out_ready = 1'b1;
        step();
        check("t5_adc_clk7", adc_clk_a, 0);
        check("t5_drained", out_valid_b, 0);
        step();
        check("t5_adc_clk8", adc_clk_a, 0);
        step();
        check("t5_adc_clk9", adc_clk_a, 0);
        en = 1'b1;
        step();
        check("t5_adc_clk10", adc_clk_a, 1);
        check("t5_nostrobe10", out_valid_b, 0);
        step();
        check("t5_nostrobe11", out_valid_b, 0);
        step();
        check("t5_adc_clk12", adc_clk_a, 0);
        check("t5_nostrobe12", out_valid_b, 0);
        step();
        check("t5_resume_v", out_valid_b, 1);
        check("t5_resume_d", out_data_b, 11);

        // 6: asynchronous reset with three samples buffered
        start(1'b1);
        run_to(20);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_pre_ovf", overflow_b, 1);
        check("t6_pre_v", out_valid_b, 1);
        check("t6_pre_d", out_data_b, 6);
        check("t6_pre_clk", adc_clk_a, 1);
        reset_n = 1'b0;
        #1;
        check("t6_async_v", out_valid_a, 0);
        check("t6_async_clk", adc_clk_a, 0);
        check("t6_async_ovf", overflow_a, 0);
        check("t6_async_drop", drop_cnt_a, 0);
        check("t6_async_d", out_data_a, 0);
        start(1'b1);
        run_to(3);
        check("t6_again_v3", out_valid_b, 0);
        step();
        check("t6_again_v", out_valid_b, 1);
        check("t6_again_d", out_data_b, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
